// File: rtl/divider_job_sequencer.sv
// Job FIFO plus handshake sequencer wrapped around the PicoBlaze 8-bit divider.
// Latency: 5 cycles job_valid->res_valid when the divider leaves Initial and finishes one cycle apart.
// Backpressure: job_ready drops while the FIFO is full; an unconsumed result stalls the FSM in CAPTURE.
//
// Ports: job_valid/job_ready/job_x/job_y  - operand pairs from the producer
//        res_valid/res_ready/res_*        - one result per job, held until accepted
//        Xin/Yin/Start/Ack/Done/Qi/Quotient/Remainder - divider handshake
//        err_timeout (sticky abort flag), busy (work in flight or queued)

// Generic register FIFO; the head entry is readable combinationally.
// Latency: a pushed entry is at the head one cycle after the push.
// Backpressure: full blocks pushes, empty blocks pops; push and pop may share a cycle.
module djs_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_vld && !empty;
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge core_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end
endmodule

// Pops jobs, runs the divider Start/Ack handshake, resolves y==0 locally, aborts on timeout.
// Latency: 5 cycles job_valid->res_valid with an ideal divider; y==0 jobs skip the divider.
// Backpressure: result port holds until res_ready; FSM waits in CAPTURE, FIFO absorbs new jobs.
module divider_job_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       ClkPort,
    input  logic       Reset_n,
    input  logic       job_valid,
    input  logic [7:0] job_x,
    input  logic [7:0] job_y,
    output logic       job_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_q,
    output logic [7:0] res_r,
    output logic       res_div0,
    output logic       res_err,
    output logic       err_timeout,
    output logic       busy,
    output logic [7:0] Xin,
    output logic [7:0] Yin,
    output logic       Start,
    output logic       Ack,
    input  logic       Done,
    input  logic       Qi,
    input  logic [7:0] Quotient,
    input  logic [7:0] Remainder
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_CAPTURE, S_ACK} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [15:0] timer_q;
    logic [7:0]  xin_q, yin_q;
    logic        start_q, ack_q;
    logic [7:0]  res_quo_q, res_rem_q;
    logic        res_div0_q, res_err_q, res_vld_q;
    logic        err_to_q;
    // Result waiting for the output port; lets CAPTURE stall without losing it.
    logic [7:0]  cap_quo_q, cap_rem_q;
    logic        cap_div0_q, cap_err_q;

    logic        fifo_full, fifo_empty, fifo_pop;
    logic [15:0] head_dat;
    logic [7:0]  head_x, head_y;
    logic        timer_hit;

    assign job_ready = !fifo_full;
    assign fifo_pop  = (state_q == S_IDLE);
    assign head_x    = head_dat[15:8];
    assign head_y    = head_dat[7:0];
    assign timer_hit = (timer_q == TIMER_LAST);

    djs_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_job_fifo (
        .core_clk (ClkPort),
        .arst_n   (Reset_n),
        .push_vld (job_valid),
        .push_dat ({job_x, job_y}),
        .pop_vld  (fifo_pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            xin_q      <= '0;
            yin_q      <= '0;
            start_q    <= 1'b0;
            ack_q      <= 1'b0;
            res_quo_q  <= '0;
            res_rem_q  <= '0;
            res_div0_q <= 1'b0;
            res_err_q  <= 1'b0;
            res_vld_q  <= 1'b0;
            err_to_q   <= 1'b0;
            cap_quo_q  <= '0;
            cap_rem_q  <= '0;
            cap_div0_q <= 1'b0;
            cap_err_q  <= 1'b0;
        end else begin
            // A consumed result drops here unless CAPTURE reloads below in the same cycle.
            if (res_vld_q && res_ready) res_vld_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (!fifo_empty) begin
                        if (head_y == 8'd0) begin
                            cap_quo_q  <= 8'hFF;
                            cap_rem_q  <= head_x;
                            cap_div0_q <= 1'b1;
                            cap_err_q  <= 1'b0;
                            state_q    <= S_CAPTURE;
                        end else begin
                            xin_q   <= head_x;
                            yin_q   <= head_y;
                            start_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer_q <= timer_q + 16'd1;
                    if (!Qi) begin
                        start_q <= 1'b0;
                        timer_q <= '0;
                        state_q <= S_WAIT_DONE;
                    end else if (timer_hit) begin
                        start_q    <= 1'b0;
                        timer_q    <= '0;
                        err_to_q   <= 1'b1;
                        cap_quo_q  <= '0;
                        cap_rem_q  <= '0;
                        cap_div0_q <= 1'b0;
                        cap_err_q  <= 1'b1;
                        state_q    <= S_CAPTURE;
                    end
                end
                S_WAIT_DONE: begin
                    timer_q <= timer_q + 16'd1;
                    if (Done) begin
                        timer_q    <= '0;
                        cap_quo_q  <= Quotient;
                        cap_rem_q  <= Remainder;
                        cap_div0_q <= 1'b0;
                        cap_err_q  <= 1'b0;
                        state_q    <= S_CAPTURE;
                    end else if (timer_hit) begin
                        timer_q    <= '0;
                        err_to_q   <= 1'b1;
                        cap_quo_q  <= '0;
                        cap_rem_q  <= '0;
                        cap_div0_q <= 1'b0;
                        cap_err_q  <= 1'b1;
                        state_q    <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    timer_q <= '0;
                    if (!res_vld_q || res_ready) begin
                        res_vld_q  <= 1'b1;
                        res_quo_q  <= cap_quo_q;
                        res_rem_q  <= cap_rem_q;
                        res_div0_q <= cap_div0_q;
                        res_err_q  <= cap_err_q;
                        // Locally resolved and aborted jobs never reached Done, so no Ack.
                        if (cap_div0_q || cap_err_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            ack_q   <= 1'b1;
                            state_q <= S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    timer_q <= '0;
                    if (!Done && Qi) begin
                        ack_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Xin         = xin_q;
    assign Yin         = yin_q;
    assign Start       = start_q;
    assign Ack         = ack_q;
    assign res_valid   = res_vld_q;
    assign res_q       = res_quo_q;
    assign res_r       = res_rem_q;
    assign res_div0    = res_div0_q;
    assign res_err     = res_err_q;
    assign err_timeout = err_to_q;
    assign busy        = (state_q != S_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_divider_job_sequencer.sv
module tb_divider_job_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk, rst_n;
    logic       job_valid, job_ready, res_valid, res_ready;
    logic [7:0] job_x, job_y, res_q, res_r, Xin, Yin, Quotient, Remainder;
    logic       res_div0, res_err, err_timeout, busy, Start, Ack, Done, Qi;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       div0;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   errs    = 0;
    int   start_cycles = 0, ack_cycles = 0, both_cycles = 0, ack_early = 0, xy_glitch = 0;
    logic prev_ack = 0, prev_ack_ok = 0, prev_active = 0, active;
    logic [15:0] prev_xy = '0;
    bit   saw_full = 0, stuck = 0, hold_comp = 0;
    int   n;

    divider_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .ClkPort     (clk),
        .Reset_n     (rst_n),
        .job_valid   (job_valid),
        .job_x       (job_x),
        .job_y       (job_y),
        .job_ready   (job_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_q       (res_q),
        .res_r       (res_r),
        .res_div0    (res_div0),
        .res_err     (res_err),
        .err_timeout (err_timeout),
        .busy        (busy),
        .Xin         (Xin),
        .Yin         (Yin),
        .Start       (Start),
        .Ack         (Ack),
        .Done        (Done),
        .Qi          (Qi),
        .Quotient    (Quotient),
        .Remainder   (Remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: Initial -> Compute -> Done -> (Ack) -> Initial.
    typedef enum logic [1:0] {D_INIT, D_COMP, D_DONE} dstate_t;
    dstate_t    ds;
    logic [7:0] dx, dy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds <= D_INIT; dx <= '0; dy <= '0; Quotient <= '0; Remainder <= '0;
        end else begin
            case (ds)
                D_INIT: if (Start && !stuck) begin ds <= D_COMP; dx <= Xin; dy <= Yin; end
                D_COMP: if (!hold_comp) begin
                    ds <= D_DONE; Quotient <= dx / dy; Remainder <= dx % dy;
                end
                D_DONE: if (Ack) ds <= D_INIT;
                default: ds <= D_INIT;
            endcase
        end
    end
    assign Qi   = (ds == D_INIT);
    assign Done = (ds == D_DONE);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one job, retrying while job_ready is low; record the expected result when accepted.
    task automatic push_job(input logic [7:0] x, input logic [7:0] y, input bit err);
        bit   acc;
        int   k;
        exp_t e;
        acc = 0; k = 0;
        job_valid = 1'b1; job_x = x; job_y = y;
        while (!acc && k < 100) begin
            acc = job_ready;
            if (!acc) saw_full = 1;
            @(posedge clk); #1;
            k++;
        end
        job_valid = 1'b0;
        check("push_accept", acc, 1);
        if (err)          e = '{q: 8'h00, r: 8'h00, div0: 1'b0, err: 1'b1};
        else if (y == 0)  e = '{q: 8'hFF, r: x,     div0: 1'b1, err: 1'b0};
        else              e = '{q: x / y, r: x % y, div0: 1'b0, err: 1'b0};
        if (acc) sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((busy || res_valid || sb.size() != 0) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pending"}, sb.size(), 0);
    endtask

    // Scoreboard pop on handshake plus handshake invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack = 0; prev_active = 0;
        end else begin
            active = Start || Ack || !Qi || Done;
            if (Start && Ack) both_cycles++;
            if (Start) start_cycles++;
            if (Ack) ack_cycles++;
            if (prev_ack && !Ack && !prev_ack_ok) ack_early++;
            if (active && prev_active && ({Xin, Yin} != prev_xy)) xy_glitch++;
            prev_ack    = Ack;
            prev_ack_ok = !Done && Qi;
            prev_active = active;
            prev_xy     = {Xin, Yin};
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", res_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("res_q", res_q, mon_e.q);
                    check("res_r", res_r, mon_e.r);
                    check("res_div0", res_div0, mon_e.div0);
                    check("res_err", res_err, mon_e.err);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit exceeded, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; job_valid = 0; job_x = 0; job_y = 0; res_ready = 1;
        #3;
        check("rst_res_valid", res_valid, 0);
        check("rst_start", Start, 0);
        check("rst_ack", Ack, 0);
        check("rst_xin", Xin, 0);
        check("rst_yin", Yin, 0);
        check("rst_res_q", res_q, 0);
        check("rst_res_r", res_r, 0);
        check("rst_flags", {res_div0, res_err, err_timeout}, 0);
        check("rst_busy", busy, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        check("job_ready_after_reset", job_ready, 1);

        // 200 / 7 with latency and handshake shape
        start_cycles = 0; ack_cycles = 0;
        push_job(8'd200, 8'd7, 0);
        n = 0;
        while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("latency", n, 5);
        check("t1_res_q", res_q, 28);
        check("t1_res_r", res_r, 4);
        check("t1_res_div0", res_div0, 0);
        drain("t1");
        check("t1_start_cycles", start_cycles, 2);
        check("t1_ack_cycles", ack_cycles, 2);

        // back-to-back jobs, in-order results
        push_job(8'd7, 8'd200, 0);
        push_job(8'd255, 8'd1, 0);
        drain("t2");
        check("t2_xin_last", Xin, 255);
        check("t2_yin_last", Yin, 1);

        // divide by zero never touches the divider
        start_cycles = 0; ack_cycles = 0;
        push_job(8'd5, 8'd0, 0);
        drain("t3");
        check("t3_start_cycles", start_cycles, 0);
        check("t3_ack_cycles", ack_cycles, 0);
        check("t3_xin_held", Xin, 255);
        check("t3_yin_held", Yin, 1);

        // backpressure: fill the FIFO with the result port blocked
        res_ready = 0; saw_full = 0;
        for (int i = 0; i < DEPTH + 2; i++) push_job(8'(10 + i * 20), 8'(3 + i), 0);
        repeat (10) @(posedge clk);
        #1;
        check("t4_job_ready_full", job_ready, 0);
        check("t4_saw_full", saw_full, 1);
        check("t4_res_valid_held", res_valid, 1);
        check("t4_busy", busy, 1);
        res_ready = 1;
        drain("t4");

        // timeout: divider never leaves Initial
        stuck = 1; start_cycles = 0; ack_cycles = 0;
        push_job(8'd9, 8'd3, 1);
        drain("t5");
        check("t5_start_cycles", start_cycles, TMO);
        check("t5_ack_cycles", ack_cycles, 0);
        check("t5_err_timeout", err_timeout, 1);
        stuck = 0;
        push_job(8'd100, 8'd10, 0);
        drain("t5b");
        check("t5_err_timeout_sticky", err_timeout, 1);

        // async reset while waiting for Done, with a second job queued
        hold_comp = 1;
        push_job(8'd60, 8'd7, 0);
        push_job(8'd1, 8'd1, 0);
        n = 0;
        while (!(!Qi && !Start) && n < 20) begin @(posedge clk); #1; n++; end
        check("t6_busy_before", busy, 1);
        #2; rst_n = 0; #1;
        check("t6_res_valid", res_valid, 0);
        check("t6_start_ack", {Start, Ack}, 0);
        check("t6_xin_yin", {Xin, Yin}, 0);
        check("t6_err_timeout", err_timeout, 0);
        check("t6_busy", busy, 0);
        sb.delete();
        hold_comp = 0;
        @(posedge clk); #2; rst_n = 1;
        @(posedge clk); #1;
        check("t6_job_ready", job_ready, 1);
        check("t6_busy_after", busy, 0);
        push_job(8'd17, 8'd5, 0);
        drain("t6");

        check("start_ack_overlap", both_cycles, 0);
        check("ack_released_early", ack_early, 0);
        check("xy_unstable", xy_glitch, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
